aq_vidu_vid_fp_uop_exp: RTL
===========================

Name: aq_vidu_vid_fp_uop_exp

Overview:
- Downstream neighbour of the vector-FP split stage.
- Consumes the split stage's held instruction and expands it into 1/2/4/8 register-group micro-ops according to its LMUL field, one micro-op per accepted handshake.
- Drives `ctrl_split_fp_dis_stall` back to the split stage, so the upstream instruction stays held until its last micro-op is accepted by the vector FP issue port.

Parameters:
- WIDTH, 180, instruction data width (matches dispatch vector width)
- LMUL_LSB, 40, LSB of the 2-bit LMUL field in the instruction data
- VD_LSB, 7, LSB of the 5-bit destination vector register field

Ports:
- split_clk  input  1  clock
- cpurst_b  input  1  reset
- rtu_yy_xx_async_flush  input  1  pipeline flush, synchronous to split_clk
- split_fp_ctrl_inst_vld  input  1  upstream instruction valid
- split_fp_dp_inst_data  input  WIDTH  upstream instruction data; held stable while stall=1
- vfpu_vidu_uop_ready  input  1  issue port accepts the presented micro-op this cycle
- ctrl_split_fp_dis_stall  output  1  upstream must hold its instruction
- vidu_vfpu_uop_vld  output  1  micro-op valid
- vidu_vfpu_uop_data  output  WIDTH  micro-op data, VD field rewritten
- vidu_vfpu_uop_idx  output  3  micro-op index within the group
- vidu_vfpu_uop_last  output  1  presented micro-op is the final one
- fp_uop_exp_busy  output  1  expansion in progress (state != IDLE); used for the upstream clock-enable OR-term

Behaviour:
- Reset: `cpurst_b` is asynchronous, active-low; the block is clocked on `split_clk`. Reset clears the state to IDLE and `idx_q` to 0.
- Reset output values: all outputs are combinational from state and inputs. With `inst_vld=0` after reset: `uop_vld=0`, `stall=0`, `idx=0`, `last=0`, `busy=0`.
- Group size: lmul = `data[LMUL_LSB+1:LMUL_LSB]`; N = 1/2/4/8 for 00/01/10/11.
- Index: `cur_idx` = `idx_q` in EXPAND, 0 in IDLE.
- `uop_vld` = `inst_vld && !flush`.
- `uop_idx` = `cur_idx`.
- `uop_last` = `uop_vld && (cur_idx == N-1)`.
- `uop_data` = input data with the VD field replaced by `(vd + cur_idx) mod 32` (5-bit wrap). All other bits pass through unchanged.
- `accept` = `uop_vld && ready`.
- Stall: `ctrl_split_fp_dis_stall` = `uop_vld && !(accept && uop_last)`. It deasserts only in the cycle the last micro-op is accepted, so upstream retires the instruction on that same edge.
- Zero-latency: data to `uop_data` is combinational. A single-uop instruction issues in the same cycle it arrives.
- FSM states: IDLE, EXPAND (1 flop) plus a 3-bit `idx_q`.
  - IDLE: on `accept && !uop_last` → EXPAND, `idx_q <= 1`. Otherwise stay in IDLE.
  - EXPAND: on `accept && uop_last` → IDLE, `idx_q <= 0`. On `accept && !uop_last` → `idx_q <= idx_q + 1`. On no accept → hold.
- Backpressure: with `ready=0`, the index, state and outputs hold. `stall` stays 1.
- Flush: `rtu_yy_xx_async_flush` has priority over everything. Next state is IDLE, `idx_q <= 0`. In the flush cycle `uop_vld=0` and `stall=0`, whatever the input valid.
- Protocol requirement on upstream: `inst_vld` and data are stable throughout EXPAND. If `inst_vld` drops in EXPAND without a flush, the block holds `idx_q` and outputs `uop_vld=0`; the bench flags this as a protocol error.
- Group size sampled live: N is recomputed from the held data every cycle and is therefore constant during a group.
- LMUL=11 with `vd > 24`: VD wraps (e.g. 28→28,29,30,31,0,1,2,3). No exception is raised here.
- Back-to-back instructions: the IDLE cycle after a group completes may immediately present the next instruction's uop 0. No bubble is required.
- Reset mid-expansion: state returns to IDLE and `idx_q` to 0. Outputs are as for the reset values.

Test Plan:
- lmul=00, vd=5, ready=1 → same cycle: `uop_vld=1`, `idx=0`, `last=1`, VD=5, `stall=0`. `busy` stays 0.
- lmul=10, vd=30, ready=1 → 4 cycles: VD 30,31,0,1; `idx` 0..3; `stall` 1,1,1,0; `last` only in cycle 4; then IDLE.
- lmul=01, ready=0 in cycle 1, then 1 → `idx` holds 0 and `stall=1` in cycle 1. `idx` 0 then 1 issued in cycles 2–3; `stall` low in cycle 3.
- lmul=11, flush asserted when `idx_q=3` → `uop_vld=0` and `stall=0` that cycle. Next cycle is IDLE with `idx=0`; a new instruction issues from uop 0.
- lmul=11, `cpurst_b` pulsed low when `idx_q=5` → immediate IDLE, `idx_q=0`, `busy=0`. After release, the held instruction restarts at `idx=0`.
- Two lmul=01 instructions back-to-back with ready=1 → 4 consecutive accepted uops: `idx` 0,1,0,1. No idle cycle in between.

Source files
------------

// File: rtl/aq_vidu_vid_fp_uop_exp.sv
// Vector-FP micro-op expander: splits the split stage's held instruction into
// 1/2/4/8 register-group micro-ops by LMUL, rewriting VD and stalling upstream.
module aq_vidu_vid_fp_uop_exp #(
  parameter int WIDTH    = 180,
  parameter int LMUL_LSB = 40,
  parameter int VD_LSB   = 7
) (
  input  logic             split_clk,
  input  logic             cpurst_b,
  input  logic             rtu_yy_xx_async_flush,
  input  logic             split_fp_ctrl_inst_vld,
  input  logic [WIDTH-1:0] split_fp_dp_inst_data,
  input  logic             vfpu_vidu_uop_ready,
  output logic             ctrl_split_fp_dis_stall,
  output logic             vidu_vfpu_uop_vld,
  output logic [WIDTH-1:0] vidu_vfpu_uop_data,
  output logic [2:0]       vidu_vfpu_uop_idx,
  output logic             vidu_vfpu_uop_last,
  output logic             fp_uop_exp_busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [2:0] cur_idx;
  logic [2:0] last_idx;
  logic       uop_vld;
  logic       uop_last;
  logic       accept;

  function automatic logic [2:0] group_last_idx(input logic [1:0] lmul);
    logic [2:0] r;
    case (lmul)
      2'b00:   r = 3'd0;
      2'b01:   r = 3'd1;
      2'b10:   r = 3'd3;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  // VD advances by the micro-op index and wraps within the 32-entry register file.
  function automatic logic [WIDTH-1:0] rewrite_vd(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       off);
    logic [WIDTH-1:0] r;
    r = d;
    r[VD_LSB +: 5] = d[VD_LSB +: 5] + {2'b00, off};
    return r;
  endfunction

  always_comb begin
    cur_idx  = (state_q == EXPAND) ? idx_q : 3'd0;
    last_idx = group_last_idx(split_fp_dp_inst_data[LMUL_LSB +: 2]);
    uop_vld  = split_fp_ctrl_inst_vld && !rtu_yy_xx_async_flush;
    uop_last = uop_vld && (cur_idx == last_idx);
    accept   = uop_vld && vfpu_vidu_uop_ready;
  end

  assign vidu_vfpu_uop_vld       = uop_vld;
  assign vidu_vfpu_uop_idx       = cur_idx;
  assign vidu_vfpu_uop_last      = uop_last;
  assign vidu_vfpu_uop_data      = rewrite_vd(split_fp_dp_inst_data, cur_idx);
  assign ctrl_split_fp_dis_stall = uop_vld && !(accept && uop_last);
  assign fp_uop_exp_busy         = (state_q == EXPAND);

  // Flush wins; otherwise only an accepted micro-op moves the group forward.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (rtu_yy_xx_async_flush) begin
      state_d = IDLE;
      idx_d   = 3'd0;
    end else if (accept) begin
      if (uop_last) begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end else begin
        state_d = EXPAND;
        idx_d   = cur_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge split_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule
